// File: rtl/sme_pkg.sv
// -----------------------------------------------------------------------------
// sme_pkg
// Shared types and constants for the SME host-side driver: FSM state and
// record-kind enums, buffer/index/counter widths, score weights, and the
// grading helper that turns one SME result into earned points.
// -----------------------------------------------------------------------------
package sme_pkg;

  localparam int SME_MAX_LEN    = 32;  // record buffer depth, also SME string limit
  localparam int SME_IDX_W      = 5;   // width of match_index
  localparam int SME_CNT_W      = 16;  // score / pattern counter width
  localparam int SME_SCORE_FLAG = 1;   // credit for a correct match flag
  localparam int SME_SCORE_IDX  = 2;   // extra credit for a correct index

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SEND   = 2'd1,
    WAIT   = 2'd2,
    REPORT = 2'd3
  } drv_state_e;

  typedef enum logic {
    KIND_STR = 1'b0,
    KIND_PAT = 1'b1
  } rec_kind_e;

  // Points earned by one SME answer against the expected (gold) answer.
  // A gold "no match" earns only the flag credit; the index is meaningless then.
  function automatic logic [1:0] sme_grade(
    input logic                 gold_match,
    input logic [SME_IDX_W-1:0] gold_index,
    input logic                 match,
    input logic [SME_IDX_W-1:0] index
  );
    logic [1:0] pts;
    pts = 2'd0;
    if (gold_match) begin
      if (match) begin
        pts = 2'(SME_SCORE_FLAG);
        if (index == gold_index) pts = 2'(SME_SCORE_FLAG + SME_SCORE_IDX);
      end
    end else if (!match) begin
      pts = 2'(SME_SCORE_FLAG);
    end
    return pts;
  endfunction

  // Full credit available for a case.
  function automatic logic [1:0] sme_full_credit(input logic gold_match);
    return gold_match ? 2'(SME_SCORE_FLAG + SME_SCORE_IDX) : 2'(SME_SCORE_FLAG);
  endfunction

endpackage

// File: rtl/sme_rec_buf.sv
// -----------------------------------------------------------------------------
// sme_rec_buf
// Single-record byte buffer. Bytes are written at wr_ptr until MAX_LEN is
// reached; further writes are dropped and flagged on ovf. wr_ptr therefore
// doubles as the saturating record length. The reader walks rd_ptr up to
// wr_ptr; clr rewinds both pointers for the next record.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   clr                rewind both pointers (record finished)
//   wr_en, wr_data     write one byte (dropped when full)
//   rd_adv             advance read pointer
//   head_data          byte 0 of the record, bypassing a same-cycle first write
//   rd_data            byte at rd_ptr
//   empty              no byte written yet (next write is the first beat)
//   rd_done            every buffered byte has been read
//   ovf                current write is past MAX_LEN
// -----------------------------------------------------------------------------
module sme_rec_buf
  import sme_pkg::*;
#(
  parameter int MAX_LEN = SME_MAX_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_adv,
  output logic [7:0] head_data,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       rd_done,
  output logic       ovf
);

  localparam int PTR_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [7:0]       mem [MAX_LEN];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;

  assign full    = (wr_ptr == PTR_W'(MAX_LEN));
  assign empty   = (wr_ptr == '0);
  assign ovf     = wr_en & full;
  assign rd_done = (rd_ptr == wr_ptr);

  // A length-1 record is written and launched on the same edge, so byte 0
  // must come straight from the write port in that case.
  assign head_data = empty ? wr_data : mem[0];
  // rd_ptr only reaches MAX_LEN together with rd_done, so the wrapped index
  // is never consumed.
  assign rd_data   = mem[rd_ptr[IDX_W-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv)         rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers gate every read,
  // and leaving it out keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[IDX_W-1:0]] <= wr_data;
  end

endmodule

// File: rtl/sme_driver.sv
// -----------------------------------------------------------------------------
// sme_driver
// Host-side driver for the string-matching engine. Loads one string or pattern
// record from a byte-stream handshake, replays it to SME as a gap-free framed
// burst, waits for SME's result on pattern records, grades it against the gold
// answer, and presents the result until the consumer takes it.
//
// Build option: define SME_DRV_TIMEOUT_EN to enable the WAIT watchdog
// (TIMEOUT_CYCLES); otherwise WAIT is unbounded and res_timeout is 0.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   in_valid/in_ready/in_data      loader byte handshake
//   in_kind, in_last               record kind (first beat), end of record
//   in_gold_match/in_gold_index    expected result (first beat of a pattern)
//   sme_chardata/isstring/ispattern  registered character stream to SME
//   sme_valid/match/match_index    SME result
//   res_valid/res_ready            result handshake
//   res_match/res_index/res_pass/res_timeout  graded result
//   score, pat_count               running totals (wrap at 2^16)
//   err_ovf                        sticky: a record exceeded MAX_LEN
// -----------------------------------------------------------------------------
module sme_driver
  import sme_pkg::*;
#(
  parameter int MAX_LEN        = SME_MAX_LEN,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  input  logic                 in_kind,
  input  logic                 in_last,
  input  logic                 in_gold_match,
  input  logic [SME_IDX_W-1:0] in_gold_index,
  output logic [7:0]           sme_chardata,
  output logic                 sme_isstring,
  output logic                 sme_ispattern,
  input  logic                 sme_valid,
  input  logic                 sme_match,
  input  logic [SME_IDX_W-1:0] sme_match_index,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_match,
  output logic [SME_IDX_W-1:0] res_index,
  output logic                 res_pass,
  output logic                 res_timeout,
  output logic [SME_CNT_W-1:0] score,
  output logic [SME_CNT_W-1:0] pat_count,
  output logic                 err_ovf
);

  drv_state_e state, state_d;

  // Record context captured on the first beat.
  rec_kind_e            kind_q, kind_d, beat_kind;
  logic                 gold_match_q, gold_match_d;
  logic [SME_IDX_W-1:0] gold_index_q, gold_index_d;

  logic [7:0]           char_d;
  logic                 isstr_d, ispat_d;
  logic                 res_match_d, res_pass_d;
  logic [SME_IDX_W-1:0] res_index_d;
  logic [SME_CNT_W-1:0] score_d, pat_count_d;
  logic                 err_ovf_d;
  logic [1:0]           pts;

  logic       buf_clr, buf_wr, buf_rd_adv;
  logic [7:0] buf_head, buf_rd_data;
  logic       buf_empty, buf_rd_done, buf_ovf;

`ifdef SME_DRV_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_d;
  logic              res_timeout_q, res_timeout_d;
  assign res_timeout = res_timeout_q;
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT_CYCLES);
  assign res_timeout    = 1'b0;
`endif

  sme_rec_buf #(.MAX_LEN(MAX_LEN)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .clr       (buf_clr),
    .wr_en     (buf_wr),
    .wr_data   (in_data),
    .rd_adv    (buf_rd_adv),
    .head_data (buf_head),
    .rd_data   (buf_rd_data),
    .empty     (buf_empty),
    .rd_done   (buf_rd_done),
    .ovf       (buf_ovf)
  );

  assign in_ready  = (state == LOAD);
  assign res_valid = (state == REPORT);

  // Kind of the beat being accepted: a single-beat record has no stored kind yet.
  assign beat_kind = buf_empty ? rec_kind_e'(in_kind) : kind_q;

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state;
    kind_d       = kind_q;
    gold_match_d = gold_match_q;
    gold_index_d = gold_index_q;
    char_d       = sme_chardata;
    isstr_d      = sme_isstring;
    ispat_d      = sme_ispattern;
    res_match_d  = res_match;
    res_index_d  = res_index;
    res_pass_d   = res_pass;
    score_d      = score;
    pat_count_d  = pat_count;
    err_ovf_d    = err_ovf;
    pts          = 2'd0;
    buf_clr      = 1'b0;
    buf_wr       = 1'b0;
    buf_rd_adv   = 1'b0;
`ifdef SME_DRV_TIMEOUT_EN
    wait_cnt_d    = wait_cnt;
    res_timeout_d = res_timeout_q;
`endif

    unique case (state)
      LOAD: begin
        if (in_valid) begin
          buf_wr = 1'b1;
          if (buf_ovf) err_ovf_d = 1'b1;
          if (buf_empty) begin
            kind_d       = rec_kind_e'(in_kind);
            gold_match_d = in_gold_match;
            gold_index_d = in_gold_index;
          end
          if (in_last) begin
            // Launch byte 0 on this edge so the burst starts next cycle.
            state_d    = SEND;
            char_d     = buf_head;
            buf_rd_adv = 1'b1;
            isstr_d    = (beat_kind == KIND_STR);
            ispat_d    = (beat_kind == KIND_PAT);
          end
        end
      end

      SEND: begin
        if (!buf_rd_done) begin
          char_d     = buf_rd_data;
          buf_rd_adv = 1'b1;
        end else begin
          isstr_d = 1'b0;
          ispat_d = 1'b0;
          buf_clr = 1'b1;
          state_d = (kind_q == KIND_PAT) ? WAIT : LOAD;
`ifdef SME_DRV_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end

      WAIT: begin
        if (sme_valid) begin
          pts         = sme_grade(gold_match_q, gold_index_q, sme_match, sme_match_index);
          res_match_d = sme_match;
          res_index_d = sme_match_index;
          res_pass_d  = (pts == sme_full_credit(gold_match_q));
          score_d     = score + SME_CNT_W'(pts);
          pat_count_d = pat_count + 1'b1;
          state_d     = REPORT;
`ifdef SME_DRV_TIMEOUT_EN
          res_timeout_d = 1'b0;
        end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          res_match_d   = 1'b0;
          res_index_d   = '0;
          res_pass_d    = 1'b0;
          res_timeout_d = 1'b1;
          pat_count_d   = pat_count + 1'b1;
          state_d       = REPORT;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
`endif
        end
      end

      REPORT: begin
        if (res_ready) state_d = LOAD;
      end

      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kind_q        <= KIND_STR;
      gold_match_q  <= 1'b0;
      gold_index_q  <= '0;
      sme_chardata  <= '0;
      sme_isstring  <= 1'b0;
      sme_ispattern <= 1'b0;
      res_match     <= 1'b0;
      res_index     <= '0;
      res_pass      <= 1'b0;
      score         <= '0;
      pat_count     <= '0;
      err_ovf       <= 1'b0;
    end else begin
      kind_q        <= kind_d;
      gold_match_q  <= gold_match_d;
      gold_index_q  <= gold_index_d;
      sme_chardata  <= char_d;
      sme_isstring  <= isstr_d;
      sme_ispattern <= ispat_d;
      res_match     <= res_match_d;
      res_index     <= res_index_d;
      res_pass      <= res_pass_d;
      score         <= score_d;
      pat_count     <= pat_count_d;
      err_ovf       <= err_ovf_d;
    end
  end

`ifdef SME_DRV_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt      <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      wait_cnt      <= wait_cnt_d;
      res_timeout_q <= res_timeout_d;
    end
  end
`endif

endmodule

// File: tb/tb_sme_driver.sv
// -----------------------------------------------------------------------------
// tb_sme_driver
// Directed bench for sme_driver. The bench plays both the record loader and the
// SME result side; expected scores and results are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_sme_driver;
  import sme_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [7:0]           in_data = '0;
  logic                 in_kind = 1'b0;
  logic                 in_last = 1'b0;
  logic                 in_gold_match = 1'b0;
  logic [SME_IDX_W-1:0] in_gold_index = '0;
  logic [7:0]           sme_chardata;
  logic                 sme_isstring;
  logic                 sme_ispattern;
  logic                 sme_valid = 1'b0;
  logic                 sme_match = 1'b0;
  logic [SME_IDX_W-1:0] sme_match_index = '0;
  logic                 res_valid;
  logic                 res_ready = 1'b0;
  logic                 res_match;
  logic [SME_IDX_W-1:0] res_index;
  logic                 res_pass;
  logic                 res_timeout;
  logic [15:0]          score;
  logic [15:0]          pat_count;
  logic                 err_ovf;

  int errors = 0;
  int checks = 0;

  logic [7:0] rec [64];
  int         rec_len;

  always #5 clk = ~clk;

`ifdef SME_DRV_TIMEOUT_EN
  sme_driver #(.MAX_LEN(32), .TIMEOUT_CYCLES(16)) dut (
`else
  sme_driver #(.MAX_LEN(32)) dut (
`endif
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_kind         (in_kind),
    .in_last         (in_last),
    .in_gold_match   (in_gold_match),
    .in_gold_index   (in_gold_index),
    .sme_chardata    (sme_chardata),
    .sme_isstring    (sme_isstring),
    .sme_ispattern   (sme_ispattern),
    .sme_valid       (sme_valid),
    .sme_match       (sme_match),
    .sme_match_index (sme_match_index),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_match       (res_match),
    .res_index       (res_index),
    .res_pass        (res_pass),
    .res_timeout     (res_timeout),
    .score           (score),
    .pat_count       (pat_count),
    .err_ovf         (err_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_rec(input string s);
    for (int i = 0; i < s.len(); i++) rec[i] = s[i];
    rec_len = s.len();
  endtask

  // Feed rec[0..rec_len-1]; kind and gold are only valid on the first beat,
  // later beats carry inverted values to prove they are ignored.
  task automatic load_rec(input logic kind, input logic gm, input logic [4:0] gi);
    for (int b = 0; b < rec_len; b++) begin
      int guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        check("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
      in_valid      = 1'b1;
      in_data       = rec[b];
      in_last       = (b == rec_len - 1);
      in_kind       = (b == 0) ? kind : ~kind;
      in_gold_match = (b == 0) ? gm : ~gm;
      in_gold_index = (b == 0) ? gi : ~gi;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Follow the burst; returns at the first negedge after framing drops.
  task automatic observe_send(input string tag, input logic exp_pat, input int exp_len);
    int   n = 0;
    logic chars_ok = 1'b1;
    logic frame_ok = 1'b1;
    @(negedge clk);
    while ((sme_isstring || sme_ispattern) && n < 60) begin
      if (sme_chardata !== rec[n]) chars_ok = 1'b0;
      if (sme_ispattern !== exp_pat || sme_isstring !== !exp_pat) frame_ok = 1'b0;
      n++;
      @(negedge clk);
    end
    check({tag, "_send_cycles"}, 32'(n), 32'(exp_len));
    check({tag, "_chars"}, 32'(chars_ok), 32'd1);
    check({tag, "_framing"}, 32'(frame_ok), 32'd1);
    check({tag, "_char_hold"}, 32'(sme_chardata), 32'(rec[exp_len-1]));
  endtask

  task automatic sme_respond(input logic m, input logic [4:0] idx);
    sme_valid       = 1'b1;
    sme_match       = m;
    sme_match_index = idx;
    @(posedge clk);
    #1;
    sme_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_result(input string tag, input logic m, input logic [4:0] idx,
                              input logic pass, input logic to,
                              input logic [15:0] sc, input logic [15:0] pc);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_res_match"}, 32'(res_match), 32'(m));
    check({tag, "_res_index"}, 32'(res_index), 32'(idx));
    check({tag, "_res_pass"}, 32'(res_pass), 32'(pass));
    check({tag, "_res_timeout"}, 32'(res_timeout), 32'(to));
    check({tag, "_score"}, 32'(score), 32'(sc));
    check({tag, "_pat_count"}, 32'(pat_count), 32'(pc));
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic ack_result(input string tag);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    check({tag, "_ack_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_ack_res_valid"}, 32'(res_valid), 32'd0);
  endtask

  task automatic run_pattern(input string tag, input string s,
                             input logic gm, input logic [4:0] gi,
                             input logic m, input logic [4:0] idx,
                             input logic pass, input logic [15:0] sc, input logic [15:0] pc);
    set_rec(s);
    load_rec(1'b1, gm, gi);
    observe_send(tag, 1'b1, s.len());
    sme_respond(m, idx);
    check_result(tag, m, idx, pass, 1'b0, sc, pc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic stable;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_chardata", 32'(sme_chardata), 32'd0);
    check("rst_framing", 32'({sme_isstring, sme_ispattern}), 32'd0);
    check("rst_res", 32'({res_valid, res_match, res_index, res_pass, res_timeout}), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_pat_count", 32'(pat_count), 32'd0);
    check("rst_err_ovf", 32'(err_ovf), 32'd0);

    // String then pattern with exact answer: +3.
    set_rec("abcdef");
    load_rec(1'b0, 1'b0, 5'd0);
    observe_send("str_abcdef", 1'b0, 6);
    check("str_no_result", 32'(res_valid), 32'd0);
    run_pattern("pat_cd", "cd", 1'b1, 5'd2, 1'b1, 5'd2, 1'b1, 16'd3, 16'd1);
    ack_result("pat_cd");

    // sme_valid while loading is ignored.
    sme_valid = 1'b1; sme_match = 1'b1; sme_match_index = 5'd3;
    @(posedge clk);
    #1;
    sme_valid = 1'b0;
    @(negedge clk);
    check("ignore_valid_res", 32'(res_valid), 32'd0);
    check("ignore_valid_pc", 32'(pat_count), 32'd1);

    // Flag right, index wrong: +1.
    run_pattern("idx_wrong", "bc", 1'b1, 5'd4, 1'b1, 5'd5, 1'b0, 16'd4, 16'd2);
    ack_result("idx_wrong");
    // Gold no-match, SME no-match: +1, full credit.
    run_pattern("gold0_ok", "xyz", 1'b0, 5'd7, 1'b0, 5'd0, 1'b1, 16'd5, 16'd3);
    ack_result("gold0_ok");
    // Length-1 pattern, exact: +3; then hold the result for 10 cycles.
    run_pattern("len1", "e", 1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 16'd8, 16'd4);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_match !== 1'b1 || res_index !== 5'd4 ||
          res_pass !== 1'b1 || score !== 16'd8 || pat_count !== 16'd4 || in_ready !== 1'b0)
        stable = 1'b0;
    end
    check("hold_stable", 32'(stable), 32'd1);
    ack_result("hold");
    // Gold match, SME says no match: +0.
    run_pattern("flag_wrong", "ab", 1'b1, 5'd2, 1'b0, 5'd2, 1'b0, 16'd8, 16'd5);
    ack_result("flag_wrong");
    // Gold no-match, SME reports match: +0.
    run_pattern("gold0_bad", "q", 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 16'd8, 16'd6);
    ack_result("gold0_bad");

`ifdef SME_DRV_TIMEOUT_EN
    begin
      int k;
      set_rec("zz");
      load_rec(1'b1, 1'b1, 5'd1);
      observe_send("timeout", 1'b1, 2);
      k = 1;
      while (!res_valid && k < 100) begin
        @(negedge clk);
        k++;
      end
      check("timeout_cycle", 32'(k), 32'd17);
      check_result("timeout", 1'b0, 5'd0, 1'b0, 1'b1, 16'd8, 16'd7);
      ack_result("timeout");
    end
`endif

    // 35-byte record: 32 bytes sent, overflow flagged.
    for (int i = 0; i < 35; i++) rec[i] = 8'(i + 1);
    rec_len = 35;
    load_rec(1'b0, 1'b0, 5'd0);
    observe_send("ovf35", 1'b0, 32);
    check("ovf35_err_ovf", 32'(err_ovf), 32'd1);

    // Reset during the 3rd SEND cycle.
    set_rec("0123456789");
    load_rec(1'b0, 1'b0, 5'd0);
    repeat (3) @(negedge clk);
    check("rst_mid_pre_frame", 32'(sme_isstring), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_framing", 32'({sme_isstring, sme_ispattern}), 32'd0);
    check("rst_mid_score", 32'(score), 32'd0);
    check("rst_mid_pc", 32'(pat_count), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_err_ovf", 32'(err_ovf), 32'd0);
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (res_valid !== 1'b0 || sme_isstring !== 1'b0 || sme_ispattern !== 1'b0) stable = 1'b0;
      @(negedge clk);
    end
    check("rst_mid_quiet", 32'(stable), 32'd1);

    // Exactly 32 bytes from reset: no overflow.
    for (int i = 0; i < 32; i++) rec[i] = 8'(8'h80 + i);
    rec_len = 32;
    load_rec(1'b0, 1'b0, 5'd0);
    observe_send("full32", 1'b0, 32);
    check("full32_err_ovf", 32'(err_ovf), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
